param_sorter: RTL and testbench



---
 rtl/param_sorter.sv | 159 +++++++++++++++
 tb/tb_param_sorter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_sorter.sv
// In-place bubble sorter over a DEPTH x WIDTH register array.
// One compare-and-swap per cycle, with selectable direction, signed compare and a saturating swap counter.
module param_sorter #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 256,
  parameter int SIGNED_CMP = 0,
  parameter int CNT_W      = 16,
  localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              Clk,
  input  logic              Rst_N,
  input  logic              Wr_En,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [WIDTH-1:0]  Wr_Data,
  input  logic [ADDR_W-1:0] Rd_Addr,
  output logic [WIDTH-1:0]  Rd_Data,
  input  logic              Start,
  input  logic              Mode,
  output logic              Busy,
  output logic              Done,
  output logic [CNT_W-1:0]  Swap_Count
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CMP      = 2'd1;
  localparam logic [1:0] S_PASS_END = 2'd2;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0]  SIGN_MASK = (SIGNED_CMP != 0) ? (WIDTH'(1) << (WIDTH-1)) : '0;
  localparam logic [ADDR_W-1:0] LIM_INIT  = ADDR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_j;
  logic [ADDR_W-1:0] r_lim;
  logic              r_swapped;
  logic              r_mode;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_swapCount;
  logic [WIDTH-1:0]  r_rdData;

  logic [ADDR_W-1:0] w_jNext;
  logic [WIDTH-1:0]  w_lo;
  logic [WIDTH-1:0]  w_hi;
  logic [WIDTH-1:0]  w_loKey;
  logic [WIDTH-1:0]  w_hiKey;
  logic              w_swap;
  logic              w_lastCmp;
  logic              w_wrAccept;
  logic              w_wrInRange;
  logic              w_rdInRange;

  assign w_jNext   = r_j + ADDR_W'(1);
  assign w_lo      = r_mem[r_j];
  assign w_hi      = r_mem[w_jNext];
  assign w_loKey   = w_lo ^ SIGN_MASK;
  assign w_hiKey   = w_hi ^ SIGN_MASK;
  assign w_swap    = (r_state == S_CMP) && (r_mode ? (w_loKey < w_hiKey) : (w_loKey > w_hiKey));
  assign w_lastCmp = (r_j == r_lim - ADDR_W'(1));
  assign w_wrAccept = Wr_En && !r_busy && w_wrInRange;

  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_fullRange
      assign w_wrInRange = 1'b1;
      assign w_rdInRange = 1'b1;
    end else begin : g_partRange
      assign w_wrInRange = (32'(Wr_Addr) < DEPTH);
      assign w_rdInRange = (32'(Rd_Addr) < DEPTH);
    end
  endgenerate

  // Swaps and host writes never coincide because writes are only taken while idle.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_swap) begin
      r_mem[r_j]     <= w_hi;
      r_mem[w_jNext] <= w_lo;
    end else if (w_wrAccept) begin
      r_mem[Wr_Addr] <= Wr_Data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      r_rdData <= '0;
    end else begin
      r_rdData <= w_rdInRange ? r_mem[Rd_Addr] : '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      r_state     <= S_IDLE;
      r_j         <= '0;
      r_lim       <= '0;
      r_swapped   <= 1'b0;
      r_mode      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_swapCount <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state     <= S_CMP;
            r_j         <= '0;
            r_lim       <= LIM_INIT;
            r_swapped   <= 1'b0;
            r_swapCount <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b1;
            r_mode      <= Mode;
          end
        end
        S_CMP: begin
          if (w_swap) begin
            r_swapped <= 1'b1;
            if (r_swapCount != CNT_MAX) begin
              r_swapCount <= r_swapCount + CNT_W'(1);
            end
          end
          if (w_lastCmp) begin
            r_state <= S_PASS_END;
          end else begin
            r_j <= w_jNext;
          end
        end
        S_PASS_END: begin
          // A clean pass means the array is ordered; lim==1 means the last pair was just settled.
          if (!r_swapped || (r_lim == ADDR_W'(1))) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_lim     <= r_lim - ADDR_W'(1);
            r_j       <= '0;
            r_swapped <= 1'b0;
            r_state   <= S_CMP;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Rd_Data    = r_rdData;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign Swap_Count = r_swapCount;

endmodule

// File: tb/tb_param_sorter.sv
// Scoreboard bench for param_sorter across several parameter sets sharing one stimulus bus.
// Expected contents, swap counts and busy lengths come from an order-statistics model of bubble sort.
module tb_param_sorter;

  localparam int NDUT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic [2:0]  sel;
  logic        wrEn;
  logic        start;
  logic        mode;
  logic [7:0]  wrAddr;
  logic [7:0]  rdAddr;
  logic [15:0] wrData;
  logic        rdReq;
  logic        rdValid;

  logic [15:0] rdA, rdD, rdE;
  logic [7:0]  rdB, rdC;
  logic [15:0] swA, swB, swC, swD;
  logic [2:0]  swE;
  logic [NDUT-1:0] busyV, doneV;

  logic [15:0] rdMux, swMux;
  logic        busyMux, doneMux;

  param_sorter #(.WIDTH(16), .DEPTH(8), .SIGNED_CMP(0), .CNT_W(16)) dutA (
    .Clk(clk), .Rst_N(rstN), .Wr_En(wrEn && sel == 3'd0), .Wr_Addr(wrAddr[2:0]), .Wr_Data(wrData),
    .Rd_Addr(rdAddr[2:0]), .Rd_Data(rdA), .Start(start && sel == 3'd0), .Mode(mode),
    .Busy(busyV[0]), .Done(doneV[0]), .Swap_Count(swA));

  param_sorter #(.WIDTH(8), .DEPTH(8), .SIGNED_CMP(1), .CNT_W(16)) dutB (
    .Clk(clk), .Rst_N(rstN), .Wr_En(wrEn && sel == 3'd1), .Wr_Addr(wrAddr[2:0]), .Wr_Data(wrData[7:0]),
    .Rd_Addr(rdAddr[2:0]), .Rd_Data(rdB), .Start(start && sel == 3'd1), .Mode(mode),
    .Busy(busyV[1]), .Done(doneV[1]), .Swap_Count(swB));

  param_sorter #(.WIDTH(8), .DEPTH(8), .SIGNED_CMP(0), .CNT_W(16)) dutC (
    .Clk(clk), .Rst_N(rstN), .Wr_En(wrEn && sel == 3'd2), .Wr_Addr(wrAddr[2:0]), .Wr_Data(wrData[7:0]),
    .Rd_Addr(rdAddr[2:0]), .Rd_Data(rdC), .Start(start && sel == 3'd2), .Mode(mode),
    .Busy(busyV[2]), .Done(doneV[2]), .Swap_Count(swC));

  param_sorter dutD (
    .Clk(clk), .Rst_N(rstN), .Wr_En(wrEn && sel == 3'd3), .Wr_Addr(wrAddr), .Wr_Data(wrData),
    .Rd_Addr(rdAddr), .Rd_Data(rdD), .Start(start && sel == 3'd3), .Mode(mode),
    .Busy(busyV[3]), .Done(doneV[3]), .Swap_Count(swD));

  param_sorter #(.WIDTH(16), .DEPTH(6), .SIGNED_CMP(0), .CNT_W(3)) dutE (
    .Clk(clk), .Rst_N(rstN), .Wr_En(wrEn && sel == 3'd4), .Wr_Addr(wrAddr[2:0]), .Wr_Data(wrData),
    .Rd_Addr(rdAddr[2:0]), .Rd_Data(rdE), .Start(start && sel == 3'd4), .Mode(mode),
    .Busy(busyV[4]), .Done(doneV[4]), .Swap_Count(swE));

  // The selected instance's outputs are presented to the monitor on one set of wires.
  always_comb begin
    rdMux = rdA;
    swMux = swA;
    case (sel)
      3'd1: begin rdMux = {8'h00, rdB}; swMux = swB; end
      3'd2: begin rdMux = {8'h00, rdC}; swMux = swC; end
      3'd3: begin rdMux = rdD; swMux = swD; end
      3'd4: begin rdMux = rdE; swMux = {13'd0, swE}; end
      default: begin rdMux = rdA; swMux = swA; end
    endcase
    busyMux = busyV[sel];
    doneMux = doneV[sel];
  end

  int depthOf  [NDUT] = '{8, 8, 8, 256, 6};
  int widthOf  [NDUT] = '{16, 8, 8, 16, 16};
  int signedOf [NDUT] = '{0, 1, 0, 0, 0};
  int cntMaxOf [NDUT] = '{65535, 65535, 65535, 65535, 7};

  int model [NDUT][256];
  bit sorting;

  int asserts  = 0;
  int failures = 0;

  typedef struct { int addr; int value; } rdExp_t;
  typedef struct { int cycles; int swaps; } doneExp_t;
  rdExp_t   rdQ[$];
  doneExp_t doneQ[$];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    asserts++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(posedge clk) rdValid <= rdReq;

  // Monitor: pops read expectations one cycle after each request and completion
  // expectations whenever Busy falls outside reset.
  initial begin : monitor
    int busyCount;
    bit prevBusy;
    rdExp_t re;
    doneExp_t de;
    busyCount = 0;
    prevBusy  = 1'b0;
    forever begin
      @(negedge clk);
      checkOutput("busyDoneExclusive", longint'(busyMux && doneMux), 0);
      if (rdValid) begin
        if (rdQ.size() == 0) begin
          checkOutput("unexpectedRead", 1, 0);
        end else begin
          re = rdQ.pop_front();
          checkOutput($sformatf("dut%0d rdData[%0d]", sel, re.addr), rdMux, re.value);
        end
      end
      if (!rstN) begin
        prevBusy  = 1'b0;
        busyCount = 0;
      end else begin
        if (busyMux) begin
          busyCount++;
        end else if (prevBusy) begin
          if (doneQ.size() == 0) begin
            checkOutput("unexpectedCompletion", 1, 0);
          end else begin
            de = doneQ.pop_front();
            checkOutput($sformatf("dut%0d busyCycles", sel), busyCount, de.cycles);
            checkOutput($sformatf("dut%0d swapCount", sel), swMux, de.swaps);
            checkOutput($sformatf("dut%0d doneAfterSort", sel), doneMux, 1);
          end
          busyCount = 0;
        end
        prevBusy = busyMux;
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int keyOf(input int s, input int v);
    if (signedOf[s] != 0 && v >= (1 << (widthOf[s] - 1))) return v - (1 << widthOf[s]);
    return v;
  endfunction

  // True when a left-hand value a and right-hand value b are in the wrong order.
  function automatic bit outOfOrder(input int s, input bit m, input int a, input int b);
    return m ? (keyOf(s, a) < keyOf(s, b)) : (keyOf(s, a) > keyOf(s, b));
  endfunction

  // Bubble sort swaps equal the inversion count; passes with swaps equal the largest
  // number of out-of-order elements to the left of any entry, plus one clean pass.
  task automatic predictSort(input int s, input bit m, output int cycles, output int swaps);
    int d, inv, lmax, c, passes, best;
    int rem[$];
    d = depthOf[s];
    inv = 0;
    lmax = 0;
    for (int i = 0; i < d; i++) begin
      c = 0;
      for (int k = 0; k < i; k++) if (outOfOrder(s, m, model[s][k], model[s][i])) c++;
      inv += c;
      if (c > lmax) lmax = c;
    end
    passes = (lmax + 1 < d - 1) ? lmax + 1 : d - 1;
    cycles = 0;
    for (int p = 0; p < passes; p++) cycles += d - p;
    swaps = (inv > cntMaxOf[s]) ? cntMaxOf[s] : inv;
    rem.delete();
    for (int i = 0; i < d; i++) rem.push_back(model[s][i]);
    for (int i = 0; i < d; i++) begin
      best = 0;
      for (int k = 1; k < rem.size(); k++) if (outOfOrder(s, m, rem[best], rem[k])) best = k;
      model[s][i] = rem[best];
      rem.delete(best);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int addr, input int data);
    wrEn   = 1'b1;
    wrAddr = 8'(addr);
    wrData = 16'(data);
    if (!sorting && addr < depthOf[sel]) model[sel][addr] = data;
    step();
    wrEn = 1'b0;
  endtask

  task automatic loadArray(input int vals[$]);
    for (int i = 0; i < vals.size(); i++) applyStimulus(i, vals[i]);
  endtask

  task automatic loadRandom(input int maxVal);
    for (int i = 0; i < depthOf[sel]; i++) applyStimulus(i, int'($urandom_range(0, maxVal)));
  endtask

  task automatic startSort(input bit m, input bit doWrite, input int addr, input int data);
    doneExp_t de;
    if (doWrite) begin
      wrEn   = 1'b1;
      wrAddr = 8'(addr);
      wrData = 16'(data);
      if (addr < depthOf[sel]) model[sel][addr] = data;
    end
    predictSort(int'(sel), m, de.cycles, de.swaps);
    doneQ.push_back(de);
    mode  = m;
    start = 1'b1;
    step();
    start   = 1'b0;
    wrEn    = 1'b0;
    sorting = 1'b1;
  endtask

  task automatic waitDone();
    int budget;
    bit finished;
    budget = depthOf[sel] * depthOf[sel] / 2 + depthOf[sel] + 20;
    finished = 1'b0;
    for (int n = 0; n < budget && !finished; n++) begin
      step();
      if (!busyMux) finished = 1'b1;
    end
    if (!finished) checkOutput("sortTimeout", 1, 0);
    sorting = 1'b0;
    step();
  endtask

  task automatic readAll(input int n);
    rdExp_t re;
    for (int i = 0; i < n; i++) begin
      rdAddr   = 8'(i);
      rdReq    = 1'b1;
      re.addr  = i;
      re.value = (i < depthOf[sel]) ? model[sel][i] : 0;
      rdQ.push_back(re);
      step();
    end
    rdReq = 1'b0;
    step();
    step();
  endtask

  task automatic asyncReset();
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("resetBusy", busyMux, 0);
    checkOutput("resetDone", doneMux, 0);
    checkOutput("resetSwapCount", swMux, 0);
    step();
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    for (int s = 0; s < NDUT; s++) for (int i = 0; i < 256; i++) model[s][i] = 0;
    doneQ.delete();
    sorting = 1'b0;
    step();
  endtask

  initial begin : stimulus
    int vals[$];
    rstN = 1'b0; sel = 3'd0; wrEn = 1'b0; start = 1'b0; mode = 1'b0;
    wrAddr = '0; rdAddr = '0; wrData = '0; rdReq = 1'b0; sorting = 1'b0;
    for (int s = 0; s < NDUT; s++) for (int i = 0; i < 256; i++) model[s][i] = 0;
    repeat (3) step();
    rstN = 1'b1;
    step();
    for (int s = 0; s < NDUT; s++) begin
      sel = 3'(s);
      #1;
      checkOutput($sformatf("dut%0d initBusy", s), busyMux, 0);
      checkOutput($sformatf("dut%0d initDone", s), doneMux, 0);
      checkOutput($sformatf("dut%0d initSwap", s), swMux, 0);
    end

    $display("[TB] async reset mid-sort with random contents");
    sel = 3'd0;
    loadRandom(65535);
    startSort(1'b0, 1'b0, 0, 0);
    repeat (3) step();
    asyncReset();
    readAll(8);

    $display("[TB] reversed 8..1 ascending");
    vals = {8, 7, 6, 5, 4, 3, 2, 1};
    loadArray(vals);
    startSort(1'b0, 1'b0, 0, 0);
    waitDone();
    readAll(8);

    $display("[TB] already sorted, then restart from Done");
    vals = {1, 2, 3, 4, 5, 6, 7, 8};
    loadArray(vals);
    startSort(1'b0, 1'b0, 0, 0);
    waitDone();
    readAll(8);
    repeat (4) step();
    checkOutput("doneHeld", doneMux, 1);
    startSort(1'b0, 1'b0, 0, 0);
    checkOutput("doneClearedOnStart", doneMux, 0);
    checkOutput("busyOnStart", busyMux, 1);
    waitDone();

    $display("[TB] descending with duplicates");
    vals = {5, 5, 3, 9, 3, 0, 9, 1};
    loadArray(vals);
    startSort(1'b1, 1'b0, 0, 0);
    waitDone();
    readAll(8);

    $display("[TB] signed and unsigned 8-bit compare");
    vals = {8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'hFE, 8'h40, 8'hC0};
    sel = 3'd1;
    loadArray(vals);
    startSort(1'b0, 1'b0, 0, 0);
    waitDone();
    readAll(8);
    sel = 3'd2;
    loadArray(vals);
    startSort(1'b0, 1'b0, 0, 0);
    waitDone();
    readAll(8);

    $display("[TB] write with start, ignored start/write/mode mid-sort");
    sel = 3'd0;
    loadRandom(65535);
    startSort(1'b0, 1'b1, 3, int'($urandom_range(0, 65535)));
    repeat (4) step();
    start = 1'b1;
    mode  = 1'b1;
    applyStimulus(0, int'($urandom_range(0, 65535)));
    start = 1'b0;
    waitDone();
    readAll(8);
    loadRandom(65535);
    startSort(1'b1, 1'b0, 0, 0);
    repeat (5) step();
    asyncReset();
    loadRandom(65535);
    startSort(1'b1, 1'b0, 0, 0);
    waitDone();
    readAll(8);

    $display("[TB] non power-of-two depth and counter saturation");
    sel = 3'd4;
    loadRandom(65535);
    applyStimulus(6, 16'h1234);
    applyStimulus(7, 16'hBEEF);
    readAll(8);
    vals = {6, 5, 4, 3, 2, 1};
    loadArray(vals);
    startSort(1'b0, 1'b0, 0, 0);
    waitDone();
    readAll(8);

    $display("[TB] random sorts with small value range");
    for (int it = 0; it < 6; it++) begin
      sel = 3'(it % 3);
      loadRandom(it < 3 ? 7 : 255);
      startSort(1'($urandom_range(0, 1)), 1'b0, 0, 0);
      waitDone();
      readAll(8);
    end

    $display("[TB] default 256x16 descending random");
    sel = 3'd3;
    loadRandom(65535);
    startSort(1'b1, 1'b0, 0, 0);
    waitDone();
    readAll(256);
    repeat (5) step();
    checkOutput("bigDoneHeld", doneMux, 1);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
